// File: rtl/stove_controller.sv
`default_nettype none
// ============================================================================
// Module   : stove_controller
// Brief    : Single-burner hotplate sequencer that handles power and level
//            events, drives a slot-based heater duty cycle, performs idle
//            auto-off, and indicates residual heat.
// Revision : 1.0 - initial release
// ============================================================================
module stove_controller #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int MAX_LEVEL   = 9,
  parameter int SLOT_CYCLES = 5_000_000,
  parameter int IDLE_S      = 10,
  parameter int COOL_S      = 30
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic       power_toggle,
  input  logic       level_up,
  input  logic       level_down,
  output logic       power_on,
  output logic [3:0] heat_level,
  output logic       heater_out,
  output logic       hot
);

  localparam int c_TICK_W = (CLK_HZ > 1)      ? $clog2(CLK_HZ)      : 1;
  localparam int c_CYC_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int c_IDLE_W = $clog2(IDLE_S + 1);
  localparam int c_COOL_W = $clog2(COOL_S + 1);

  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(CLK_HZ - 1);
  localparam logic [c_CYC_W-1:0]  c_CYC_LAST  = c_CYC_W'(SLOT_CYCLES - 1);
  localparam logic [3:0]          c_SLOT_LAST = 4'(MAX_LEVEL - 1);
  localparam logic [3:0]          c_LVL_MAX   = 4'(MAX_LEVEL);
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = c_IDLE_W'(IDLE_S);
  localparam logic [c_COOL_W-1:0] c_COOL_MAX  = c_COOL_W'(COOL_S);

  typedef enum logic [0:0] {
    S_OFF = 1'b0,
    S_ON  = 1'b1
  } state_t;

  state_t              r_state;
  logic [3:0]          r_level;
  logic [c_IDLE_W-1:0] r_idle;
  logic [c_COOL_W-1:0] r_cool;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [c_CYC_W-1:0]  r_cyc;
  logic [3:0]          r_slot;
  logic                r_heater;
  logic                r_hot;

  logic w_tick;
  logic w_slot_wrap;
  logic w_up_only;
  logic w_dn_only;
  logic w_any_level;

  assign w_tick      = (r_tick_cnt == c_TICK_LAST);
  assign w_slot_wrap = (r_cyc == c_CYC_LAST);
  assign w_up_only   = level_up & ~level_down;
  assign w_dn_only   = level_down & ~level_up;
  assign w_any_level = level_up | level_down;

  // One-second prescaler, free-running from reset
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_cyc  <= '0;
      r_slot <= '0;
    end else if (w_slot_wrap) begin
      r_cyc  <= '0;
      r_slot <= (r_slot == c_SLOT_LAST) ? 4'd0 : r_slot + 4'd1;
    end else begin
      r_cyc  <= r_cyc + 1'b1;
    end
  end

  // Power/level FSM; a toggle outranks level events, which outrank the idle timeout
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_state <= S_OFF;
      r_level <= 4'd0;
      r_idle  <= '0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_idle <= '0;
          if (power_toggle) begin
            r_state <= S_ON;
            r_level <= 4'd0;
          end
        end
        S_ON: begin
          if (power_toggle) begin
            r_state <= S_OFF;
            r_level <= 4'd0;
            r_idle  <= '0;
          end else if (w_any_level) begin
            r_idle <= '0;
            if (w_up_only && (r_level != c_LVL_MAX)) begin
              r_level <= r_level + 4'd1;
            end else if (w_dn_only && (r_level != 4'd0)) begin
              r_level <= r_level - 4'd1;
            end
          end else if (r_idle == c_IDLE_MAX) begin
            r_state <= S_OFF;
            r_idle  <= '0;
          end else if (r_level != 4'd0) begin
            r_idle <= '0;
          end else if (w_tick) begin
            r_idle <= r_idle + 1'b1;
          end
        end
        default: begin
          r_state <= S_OFF;
          r_level <= 4'd0;
          r_idle  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_heater <= 1'b0;
      r_cool   <= '0;
      r_hot    <= 1'b0;
    end else begin
      r_heater <= (r_state == S_ON) && (r_slot < r_level);
      if (r_level != 4'd0) begin
        r_cool <= '0;
      end else if (w_tick && (r_cool != c_COOL_MAX)) begin
        r_cool <= r_cool + 1'b1;
      end
      if (r_heater) begin
        r_hot <= 1'b1;
      end else if (r_cool == c_COOL_MAX) begin
        r_hot <= 1'b0;
      end
    end
  end

  assign power_on   = (r_state == S_ON);
  assign heat_level = r_level;
  assign heater_out = r_heater;
  assign hot        = r_hot;

endmodule
`default_nettype wire

// File: tb/tb_stove_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_stove_controller
// Brief    : Directed and random stimulus for stove_controller, compared
//            each cycle against a behavioural model of the stove rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stove_controller;

  localparam int P_CLK_HZ = 10;
  localparam int P_SLOT   = 2;
  localparam int P_MAX    = 9;
  localparam int P_IDLE   = 3;
  localparam int P_COOL   = 2;

  logic       clk = 1'b0;
  logic       async_reset = 1'b0;
  logic       power_toggle = 1'b0;
  logic       level_up = 1'b0;
  logic       level_down = 1'b0;
  logic       power_on;
  logic [3:0] heat_level;
  logic       heater_out;
  logic       hot;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: m_n is the number of clock edges since reset was released
  int m_n;
  bit m_power;
  int m_level;
  int m_idle;
  int m_cool;
  bit m_heater;
  bit m_hot;

  stove_controller #(
    .CLK_HZ      (P_CLK_HZ),
    .MAX_LEVEL   (P_MAX),
    .SLOT_CYCLES (P_SLOT),
    .IDLE_S      (P_IDLE),
    .COOL_S      (P_COOL)
  ) dut (
    .clk          (clk),
    .async_reset  (async_reset),
    .power_toggle (power_toggle),
    .level_up     (level_up),
    .level_down   (level_down),
    .power_on     (power_on),
    .heat_level   (heat_level),
    .heater_out   (heater_out),
    .hot          (hot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_n = 0; m_power = 0; m_level = 0; m_idle = 0;
    m_cool = 0; m_heater = 0; m_hot = 0;
  endfunction

  function automatic void model_step(input bit pt, input bit up, input bit dn);
    bit tick;
    int slot;
    bit power_n;
    int level_n;
    int idle_n;
    int cool_n;
    bit heater_n;
    bit hot_n;
    tick     = (m_n % P_CLK_HZ) == (P_CLK_HZ - 1);
    slot     = (m_n / P_SLOT) % P_MAX;
    heater_n = m_power && (slot < m_level);
    hot_n    = m_heater ? 1'b1 : ((m_cool >= P_COOL) ? 1'b0 : m_hot);
    if (m_level > 0) cool_n = 0;
    else             cool_n = (tick && m_cool < P_COOL) ? m_cool + 1 : m_cool;
    power_n = m_power; level_n = m_level; idle_n = m_idle;
    if (!m_power) begin
      idle_n = 0;
      if (pt) begin power_n = 1; level_n = 0; end
    end else if (pt) begin
      power_n = 0; level_n = 0; idle_n = 0;
    end else if (up || dn) begin
      idle_n = 0;
      if (up && !dn) level_n = (m_level + 1 > P_MAX) ? P_MAX : m_level + 1;
      if (dn && !up) level_n = (m_level - 1 < 0) ? 0 : m_level - 1;
    end else if (m_idle >= P_IDLE) begin
      power_n = 0; idle_n = 0;
    end else if (m_level > 0) begin
      idle_n = 0;
    end else if (tick) begin
      idle_n = m_idle + 1;
    end
    m_power = power_n; m_level = level_n; m_idle = idle_n;
    m_cool = cool_n; m_heater = heater_n; m_hot = hot_n;
    m_n++;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".power_on"},   power_on,   m_power);
    chk({tag, ".heat_level"}, heat_level, m_level);
    chk({tag, ".heater_out"}, heater_out, m_heater);
    chk({tag, ".hot"},        hot,        m_hot);
  endtask

  task automatic step(input bit pt, input bit up, input bit dn);
    power_toggle = pt; level_up = up; level_down = dn;
    @(posedge clk); #1;
    model_step(pt, up, dn);
    check_all("cycle");
  endtask

  task automatic do_reset();
    power_toggle = 0; level_up = 0; level_down = 0;
    async_reset = 1;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check_all("reset");
    async_reset = 0;
  endtask

  initial begin
    int cnt;
    int k;
    bit seen;

    // Level events while off are ignored
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("off_ignore.level", heat_level, 0);
    end

    // Saturation at the top, floor at zero
    step(1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    chk("sat.level", heat_level, P_MAX);
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 0);
      chk("sat.heater", heater_out, 1);
    end
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    step(0, 0, 0);
    chk("floor.level", heat_level, 0);
    chk("floor.heater", heater_out, 0);

    // Level 3 duty: 6 of every 18 cycles high
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 36; i++) begin
      step(0, 0, 0);
      if (heater_out === 1'b1) cnt++;
    end
    chk("duty3.high_cycles", cnt, 12);
    step(1, 0, 0);
    chk("poweroff.power_on", power_on, 0);
    chk("poweroff.level", heat_level, 0);
    step(0, 0, 0);
    chk("poweroff.heater", heater_out, 0);

    // Idle auto-off at level 0
    do_reset();
    step(1, 0, 0);
    k = 0; seen = 0;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0);
      if (!seen && power_on === 1'b0) begin seen = 1; k = i; end
    end
    chk("autooff.window", (k >= 21 && k <= 31), 1);

    // Periodic level events keep it on
    step(1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 18; i++) step(0, 0, 0);
      step(0, 1, 0);
      step(0, 0, 1);
      chk("keepalive.power_on", power_on, 1);
    end

    // Residual heat hold and simultaneous up/down
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("hot.set", hot, 1);
    step(0, 1, 1);
    chk("updown.level", heat_level, 5);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    chk("cool.level", heat_level, 0);
    k = 0; seen = 0;
    for (int i = 1; i <= 30; i++) begin
      step(0, 0, 0);
      if (!seen && hot === 1'b0) begin seen = 1; k = i; end
    end
    chk("cool.clear_window", (k >= 12 && k <= 21), 1);

    // Async reset mid-PWM at level 7 with hot set
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("areset.pre_hot", hot, 1);
    chk("areset.pre_level", heat_level, 7);
    #2 async_reset = 1;
    #1;
    chk("areset.power_on", power_on, 0);
    chk("areset.level", heat_level, 0);
    chk("areset.heater", heater_out, 0);
    chk("areset.hot", hot, 0);
    model_reset();
    @(posedge clk); #1;
    async_reset = 0;

    // Random event stream against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stove_controller.md
# stove_controller

Hotplate sequencing controller for the single-burner stove design on the DE0 board. Consumes one-cycle event pulses from the button front-end (long-press power toggle, short-press up/down), holds the power state and heat level, drives the heating element with a slot-based duty cycle, and performs idle auto-off and residual-heat indication. Sits between the debounced button/long-press detectors and the heater output and display drivers.

## Interface

- CLK_HZ, 50_000_000, clock cycles per one-second tick
- MAX_LEVEL, 9, highest heat level (levels 0..MAX_LEVEL)
- SLOT_CYCLES, 5_000_000, cycles per duty slot; one duty period = MAX_LEVEL slots
- IDLE_S, 10, seconds at level 0 while on before auto-off
- COOL_S, 30, seconds with heater unused before hot indicator clears

- clk  in  1  system clock, rising edge
- async_reset  in  1  asynchronous, active-high reset
- power_toggle  in  1  one-cycle pulse, toggle power
- level_up  in  1  one-cycle pulse, increment level
- level_down  in  1  one-cycle pulse, decrement level
- power_on  out  1  stove on
- heat_level  out  4  current level, 0..MAX_LEVEL
- heater_out  out  1  heating element drive
- hot  out  1  residual-heat indicator

## Operation

- Reset: power_on=0, heat_level=0, heater_out=0, hot=0; all counters 0; state OFF.
- States: OFF, ON.
  - OFF: level_up/level_down ignored; power_toggle -> ON, heat_level=0, idle counter cleared.
  - ON: power_toggle -> OFF, heat_level forced to 0 in the same update.
- Event priority, same cycle: power_toggle beats up/down; level_up and level_down together (without power_toggle) -> no change, but idle counter still cleared.
- Level arithmetic: up at MAX_LEVEL saturates at MAX_LEVEL; down at 0 stays 0. No wrap.
- Second tick: free-running prescaler 0..CLK_HZ-1 from reset, tick high one cycle when count==CLK_HZ-1. Not restarted by events.
- Idle auto-off: in ON with heat_level==0, idle counter increments per tick; cleared on entering ON, on any level_up/level_down pulse, and while heat_level>0. Reaching IDLE_S -> OFF on the cycle after that tick. Timeout therefore fires between IDLE_S-1 and IDLE_S seconds after the last clear.
- Duty: free-running cycle counter 0..SLOT_CYCLES-1 and slot index 0..MAX_LEVEL-1 (slot advances at cycle counter wrap, wraps to 0 after MAX_LEVEL-1). heater_out = power_on && (slot_index < heat_level), registered. Level MAX_LEVEL -> constant high; level 0 -> constant low.
- Hot: set on any cycle heater_out==1. Cool counter cleared while heat_level>0; otherwise increments per tick, saturating at COOL_S. hot clears when cool counter reaches COOL_S. Toggling power does not clear hot.
- Reset mid-operation: all state returns immediately to reset values, including hot=0.

## Timing

- All outputs registered; no combinational input-to-output path.
- Event pulse sampled at edge N -> power_on/heat_level updated after edge N; heater_out reflects the new level after edge N+1.
- Power-off: heater_out low no later than one cycle after power_on falls.
- Auto-off: power_on falls one cycle after the IDLE_S-th qualifying tick.
- Inputs assumed synchronous to clk and at most one cycle wide; a multi-cycle pulse counts once per high cycle.

## Test plan

Parameters for bench: CLK_HZ=10, SLOT_CYCLES=2, MAX_LEVEL=9, IDLE_S=3, COOL_S=2.

- Reset then level_up x3 while OFF -> power_on=0, heat_level=0, heater_out=0 throughout.
- power_toggle, level_up x12 -> heat_level saturates at 9, heater_out constant 1; level_down x12 -> heat_level 0, heater_out 0.
- ON, level 3 -> heater_out high for 6 of every 18 cycles, low for 12, repeating; power_toggle -> power_on=0, heat_level=0, heater_out 0 one cycle later.
- ON at level 0, no events -> power_on falls 1 cycle after 3rd tick (within 21..31 cycles); repeat with level_up,level_down every 20 cycles -> stays on.
- Heat at level 5 then level_down to 0 -> hot stays 1 until cool counter reaches 2 ticks, then 0; level_up and level_down in the same cycle -> heat_level unchanged.
- async_reset asserted mid-PWM at level 7, hot=1 -> all outputs 0 immediately, without waiting for a clk edge.
